// File: rtl/hopfield_datapath.sv
// Neuron state vector and symmetric signed weight matrix for a Hopfield network:
// one-neuron-per-cycle asynchronous recall, one-cycle saturating Hebbian learning.
module hopfield_datapath #(
  parameter int NEURON_COUNT = 8,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NEURON_COUNT-1:0]         pattern_in,
  input  logic                            modify_neuron,
  input  logic                            modify_neuron_using_input,
  input  logic                            modify_weights,
  output logic                            same_input,
  output logic                            converged,
  output logic [NEURON_COUNT-1:0]         state_out,
  output logic [$clog2(NEURON_COUNT)-1:0] update_idx
);

  localparam int N     = NEURON_COUNT;
  localparam int W     = WEIGHT_WIDTH;
  localparam int IDX_W = $clog2(N);
  localparam int ACC_W = W + IDX_W + 1;
  localparam logic signed [W-1:0] W_MAX    = W'((1 << (W - 1)) - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N - 1);

  logic signed [W-1:0]     weights [N][N];
  logic [N-1:0]            prev_pattern;
  logic                    prev_valid;
  logic                    sweep_clean;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic                    next_bit;
  logic                    flip;
  logic                    last;

  // Local field of the neuron being updated; a zero field keeps the old state.
  always_comb begin
    acc  = '0;
    term = '0;
    for (int j = 0; j < N; j++) begin
      term = ACC_W'(weights[update_idx][j]);
      if (IDX_W'(j) != update_idx) begin
        acc = state_out[j] ? (acc + term) : (acc - term);
      end
    end
    if (acc > 0) begin
      next_bit = 1'b1;
    end else if (acc < 0) begin
      next_bit = 1'b0;
    end else begin
      next_bit = state_out[update_idx];
    end
    flip = (next_bit != state_out[update_idx]);
    last = (update_idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_out    <= '0;
      update_idx   <= '0;
      converged    <= 1'b0;
      same_input   <= 1'b0;
      prev_pattern <= '0;
      prev_valid   <= 1'b0;
      sweep_clean  <= 1'b1;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          weights[i][j] <= '0;
        end
      end
    end else begin
      prev_pattern <= pattern_in;
      prev_valid   <= 1'b1;
      same_input   <= prev_valid && (pattern_in == prev_pattern);

      if (modify_weights) begin
        // Both triangles get the same update, so symmetry is preserved.
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            if (i == j) begin
              weights[i][j] <= '0;
            end else if (state_out[i] == state_out[j]) begin
              if (weights[i][j] != W_MAX) weights[i][j] <= weights[i][j] + W'(1);
            end else begin
              if (weights[i][j] != -W_MAX) weights[i][j] <= weights[i][j] - W'(1);
            end
          end
        end
      end else if (modify_neuron) begin
        if (modify_neuron_using_input) begin
          state_out   <= pattern_in;
          update_idx  <= '0;
          converged   <= 1'b0;
          sweep_clean <= 1'b1;
        end else begin
          state_out[update_idx] <= next_bit;
          if (last) begin
            update_idx  <= '0;
            converged   <= sweep_clean && !flip;
            sweep_clean <= 1'b1;
          end else begin
            update_idx  <= update_idx + IDX_W'(1);
            sweep_clean <= sweep_clean && !flip;
            if (flip) converged <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hopfield_datapath.sv
// Bench for hopfield_datapath: directed table and corner sequences on a 4-neuron
// instance, same_input on an 8-neuron instance, then random ops against a model.
module tb_hopfield_datapath;

  localparam int N    = 4;
  localparam int WMAX = 7;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [N-1:0] pattern;
  logic         mn, ui, mw;
  logic         same, conv;
  logic [N-1:0] st;
  logic [1:0]   idx;

  logic [7:0]   p8;
  logic         zero8;
  logic         same8, conv8;
  logic [7:0]   st8;
  logic [2:0]   idx8;

  hopfield_datapath #(.NEURON_COUNT(4), .WEIGHT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .pattern_in(pattern),
    .modify_neuron(mn), .modify_neuron_using_input(ui), .modify_weights(mw),
    .same_input(same), .converged(conv), .state_out(st), .update_idx(idx)
  );

  hopfield_datapath dut8 (
    .clk(clk), .rst(rst), .pattern_in(p8),
    .modify_neuron(zero8), .modify_neuron_using_input(zero8), .modify_weights(zero8),
    .same_input(same8), .converged(conv8), .state_out(st8), .update_idx(idx8)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input int i, input int j, input int exp);
    check($sformatf("%s w%0d%0d", name, i, j), int'(dut4.weights[i][j]), exp);
  endtask

  task automatic check_w_zero(input string name);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check_w(name, i, j, 0);
  endtask

  // driver
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [N-1:0] pat,
                       input logic n_v, input logic u_v, input logic w_v);
    rst = r; pattern = pat; mn = n_v; ui = u_v; mw = w_v;
    cycle();
  endtask

  // behavioural reference: neurons as +1/-1 integers, weights as plain ints
  int m_s [N];
  int m_w [N][N];
  int m_idx, m_conv, m_flips, m_same, m_prev_valid;
  logic [N-1:0] m_prev_pat;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_s[i] = -1;
      for (int j = 0; j < N; j++) m_w[i][j] = 0;
    end
    m_idx = 0; m_conv = 0; m_flips = 0; m_same = 0; m_prev_valid = 0; m_prev_pat = '0;
  endfunction

  function automatic void model_step(input logic r, input logic [N-1:0] pat,
                                     input logic n_v, input logic u_v, input logic w_v);
    int sum, nv, i, v;
    if (!r) begin
      model_reset();
      return;
    end
    m_same = (m_prev_valid != 0 && pat == m_prev_pat) ? 1 : 0;
    m_prev_pat = pat;
    m_prev_valid = 1;
    if (w_v) begin
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++)
          if (a != b) begin
            v = m_w[a][b] + m_s[a] * m_s[b];
            m_w[a][b] = (v > WMAX) ? WMAX : ((v < -WMAX) ? -WMAX : v);
          end
    end else if (n_v) begin
      if (u_v) begin
        for (int k = 0; k < N; k++) m_s[k] = pat[k] ? 1 : -1;
        m_idx = 0; m_conv = 0; m_flips = 0;
      end else begin
        i = m_idx;
        sum = 0;
        for (int j = 0; j < N; j++) if (j != i) sum += m_w[i][j] * m_s[j];
        nv = (sum > 0) ? 1 : ((sum < 0) ? -1 : m_s[i]);
        if (nv != m_s[i]) begin
          m_flips++;
          m_conv = 0;
        end
        m_s[i] = nv;
        if (i == N - 1) begin
          m_conv = (m_flips == 0) ? 1 : 0;
          m_flips = 0;
        end
        m_idx = (i + 1) % N;
      end
    end
  endfunction

  function automatic logic [N-1:0] model_bits();
    logic [N-1:0] b;
    for (int k = 0; k < N; k++) b[k] = (m_s[k] > 0);
    return b;
  endfunction

  typedef struct {
    logic [N-1:0] pat;
    logic         n_v, u_v, w_v;
    logic [N-1:0] e_state;
    int           e_idx;
    int           e_conv;
  } vec_t;

  vec_t tbl [11];
  int   exp_w [N][N];
  logic [N-1:0] rp;
  logic rr, rn, ru, rw;
  int   op;
  int   w01, w02;

  initial begin
    // learn 1010, load corrupted 0010, recall: neuron 3 flips, second sweep is clean
    tbl[0]  = '{4'b1010, 1'b1, 1'b1, 1'b0, 4'b1010, 0, 0};
    tbl[1]  = '{4'b1010, 1'b0, 1'b0, 1'b1, 4'b1010, 0, 0};
    tbl[2]  = '{4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 0, 0};
    tbl[3]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 1, 0};
    tbl[4]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 2, 0};
    tbl[5]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 3, 0};
    tbl[6]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b1010, 0, 0};
    tbl[7]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b1010, 1, 0};
    tbl[8]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b1010, 2, 0};
    tbl[9]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b1010, 3, 0};
    tbl[10] = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b1010, 0, 1};
    exp_w[0] = '{0, -1, 1, -1};
    exp_w[1] = '{-1, 0, -1, 1};
    exp_w[2] = '{1, -1, 0, -1};
    exp_w[3] = '{-1, 1, -1, 0};

    zero8 = 1'b0;
    p8 = 8'h00;

    // reset state
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst state", int'(st), 0);
    check("rst idx", int'(idx), 0);
    check("rst conv", int'(conv), 0);
    check("rst same", int'(same), 0);
    check_w_zero("rst");
    check("rst8 state", int'(st8), 0);
    check("rst8 idx", int'(idx8), 0);
    check("rst8 conv", int'(conv8), 0);
    check("rst8 same", int'(same8), 0);

    // same_input on the 8-neuron instance
    p8 = 8'h5A;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("same 1st", int'(same8), 0);
    cycle();
    check("same 2nd", int'(same8), 1);
    cycle();
    check("same 3rd", int'(same8), 1);
    p8 = 8'h3C;
    cycle();
    check("same change", int'(same8), 0);

    // learn / recall table
    for (int t = 0; t < 11; t++) begin
      drive(1'b1, tbl[t].pat, tbl[t].n_v, tbl[t].u_v, tbl[t].w_v);
      check($sformatf("tbl[%0d] state", t), int'(st), int'(tbl[t].e_state));
      check($sformatf("tbl[%0d] idx", t), int'(idx), tbl[t].e_idx);
      check($sformatf("tbl[%0d] conv", t), int'(conv), tbl[t].e_conv);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check_w("hebb", i, j, exp_w[i][j]);

    // saturation
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1010, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1);
    check_w("sat", 0, 2, 7);
    check_w("sat", 0, 1, -7);
    check_w("sat", 3, 0, -7);
    check_w("sat", 2, 2, 0);
    drive(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1);
    check_w("sat11", 0, 2, 7);
    check_w("sat11", 0, 1, -7);
    check_w("sat11", 1, 3, 7);
    check_w("sat11", 1, 1, 0);

    // priority: learning wins over neuron modification
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1010, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
    check("prio pre idx", int'(idx), 1);
    drive(1'b1, 4'b0101, 1'b1, 1'b1, 1'b1);
    check("prio state", int'(st), 4'b1010);
    check("prio idx", int'(idx), 1);
    check("prio conv", int'(conv), 0);
    check_w("prio", 0, 1, -1);
    check_w("prio", 0, 2, 1);
    check_w("prio", 3, 1, 1);

    // tie hold with zero weights
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
      check($sformatf("tie state %0d", k), int'(st), 4'b0110);
      check($sformatf("tie conv %0d", k), int'(conv), (k >= 3) ? 1 : 0);
    end

    // learning leaves converged/update_idx alone; then reset mid-sweep
    drive(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1);
    check("learn conv", int'(conv), 1);
    check("learn idx", int'(idx), 0);
    check_w("learn", 0, 1, -1);
    drive(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0);
    check("mid idx", int'(idx), 2);
    check("mid conv", int'(conv), 1);
    drive(1'b0, 4'b0110, 1'b1, 1'b0, 1'b1);
    check("midrst state", int'(st), 0);
    check("midrst idx", int'(idx), 0);
    check("midrst conv", int'(conv), 0);
    check("midrst same", int'(same), 0);
    check_w_zero("midrst");
    drive(1'b1, 4'b1100, 1'b1, 1'b1, 1'b0);
    check("resume state", int'(st), 4'b1100);
    drive(1'b1, 4'b1100, 1'b1, 1'b0, 1'b0);
    check("resume idx", int'(idx), 1);

    // randomized ops against the reference model
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    model_reset();
    rp = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      rr = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 1) == 0) rp = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 9);
      rw = (op == 0) || (op == 2);
      rn = (op == 1) || (op == 2) || (op >= 4);
      ru = (op == 1) || (op == 2) || ($urandom_range(0, 15) == 0);
      model_step(rr, rp, rn, ru, rw);
      drive(rr, rp, rn, ru, rw);
      check($sformatf("rnd[%0d] state", k), int'(st), int'(model_bits()));
      check($sformatf("rnd[%0d] idx", k), int'(idx), m_idx);
      check($sformatf("rnd[%0d] conv", k), int'(conv), m_conv);
      check($sformatf("rnd[%0d] same", k), int'(same), m_same);
      if (k % 25 == 24) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            check_w($sformatf("rnd[%0d]", k), i, j, m_w[i][j]);
      end
    end
    w01 = m_w[0][1];
    w02 = m_w[0][2];
    check_w("rnd end", 0, 1, w01);
    check_w("rnd end", 0, 2, w02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hopfield_datapath.md
Name: hopfield_datapath

Overview:
- Neuron/weight datapath driven by the HopfieldControl FSM.
- Consumes the FSM controls `modify_neuron`, `modify_neuron_using_input` and `modify_weights`.
- Produces the status flags `same_input` and `converged` that the FSM branches on.
- Holds the N-neuron bipolar state vector and the signed symmetric weight matrix. Performs asynchronous one-neuron-per-cycle recall and one-cycle Hebbian learning.

Parameters:
- NEURON_COUNT, 8, number of neurons N (>=2).
- WEIGHT_WIDTH, 4, signed weight width W; weights saturate at ±(2^(W-1)-1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- pattern_in  in  N  external input pattern; bit i=1 means +1, bit i=0 means -1.
- modify_neuron  in  1  from FSM: modify neuron state this cycle.
- modify_neuron_using_input  in  1  from FSM: load pattern_in instead of recall. Qualified by modify_neuron.
- modify_weights  in  1  from FSM: perform Hebbian learning this cycle.
- same_input  out  1  registered: pattern_in equal to the previous cycle's sample.
- converged  out  1  registered: a complete sweep finished with no neuron flips.
- state_out  out  N  current neuron state vector.
- update_idx  out  clog2(N)  index of the neuron updated on the next recall cycle.

Behaviour:
- Reset (rst=0 at edge):
  - state_out=0, update_idx=0, converged=0, same_input=0.
  - prev_valid=0; every weight = 0; sweep_clean=1.
  - Reset overrides all other inputs, including mid-sweep or mid-learn.
- same_input:
  - Every edge: prev_pattern<=pattern_in, prev_valid<=1, same_input<=prev_valid && (pattern_in==prev_pattern).
  - Result: high from the edge after the second consecutive identical sample.
- Priority: modify_weights > modify_neuron. When both are asserted, only learning occurs; state, update_idx and converged hold.
- Learning (modify_weights=1), one cycle, uses current state_out:
  - For all i!=j: w[i][j] += (s_i XNOR s_j) ? +1 : -1.
  - Saturate at +(2^(W-1)-1) and -(2^(W-1)-1); -2^(W-1) is never produced.
  - Diagonal w[i][i] is held 0. Matrix stays symmetric.
  - converged and update_idx are unchanged.
- Input load (modify_neuron=1, using_input=1):
  - state_out<=pattern_in, update_idx<=0, converged<=0, sweep_clean<=1.
- Recall (modify_neuron=1, using_input=0), i=update_idx:
  - sum = Σ_{j!=i} w[i][j]*b_j, with b_j=+1/-1 from state bit j.
  - Accumulator is signed, width W+clog2(N)+1; no overflow is possible.
  - sum>0 → s_i<=1; sum<0 → s_i<=0; sum==0 → s_i unchanged (tie hold).
  - flip = new s_i != old s_i.
  - update_idx wraps N-1→0.
  - If flip: converged<=0.
  - At i==N-1: converged<=sweep_clean && !flip, and sweep_clean<=1.
  - Otherwise: sweep_clean<=sweep_clean && !flip.
  - converged stays 1 across further clean sweeps; it drops on the first flip.
- Idle (no modify_*): state, weights, update_idx, converged hold.
- Output timing: all outputs are registered; a response is visible the cycle after the causing edge.

Test Plan:
- Reset, then hold pattern_in=0x5A for 3 cycles, then change to 0x3C:
  - All outputs 0 and every weight 0 after reset.
  - same_input=0 after the 1st sample, 1 after the 2nd and 3rd, 0 the cycle after 0x3C.
- Learn, then recall a corrupted pattern (N=4, W=4):
  - Load pattern 4'b1010, then one modify_weights cycle → w01=-1, w02=+1, w03=-1, w12=-1, w13=+1, w23=-1; diagonal 0.
  - Load 4'b0010, then 4 recall cycles → state_out=4'b1010; only neuron 3 flips, converged=0.
  - 4 more recall cycles → converged=1, update_idx=0.
- Saturation: N=4, W=4, learn 4'b1010 ten times → w02=+7, w01=-7, diagonal still 0; an 11th learn leaves the values unchanged.
- Priority: assert modify_weights and modify_neuron together → weights update, state_out/update_idx/converged unchanged.
- Tie hold: all weights 0, load 4'b0110, run 8 recall cycles → state_out stays 4'b0110, converged=1 after the 4th cycle.
- Reset mid-sweep: drive rst=0 at update_idx=2 with converged=1 → next cycle all outputs and weights are 0; normal operation resumes after rst returns to 1.
